nfc_ram_arb: RTL and testbench

NFC_RAM_ARB -- requirements
Module: nfc_ram_arb

---
 rtl/nfc_parameter.sv | 26 ++
 rtl/nfc_ecc_fix.sv | 80 ++++++++
 rtl/nfc_ram_arb.sv | 133 +++++++++++++
 tb/tb_nfc_ram_arb.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nfc_parameter.sv
// Shared constants and types for the NFC RAM arbiter and its ECC read-modify-write fixer.
package nfc_parameter;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    OwnNone,
    OwnMif,
    OwnFix,
    OwnHst
  } owner_e;

  typedef enum logic [1:0] {
    FixIdle,
    FixRd,
    FixCap,
    FixWr
  } fix_state_e;

  // Host byte enables are active-high, the SRAM write enables active-low.
  function automatic logic [1:0] host_wen(input logic wr, input logic [1:0] be);
    return wr ? ~be : 2'b11;
  endfunction

endpackage

// File: rtl/nfc_ecc_fix.sv
// ECC correction engine: reads a word, XORs in the error pattern and writes it back.
module nfc_ecc_fix
  import nfc_parameter::*;
#(
  parameter int unsigned DW = nfc_parameter::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_fix_req,
  input  logic [DW-1:0] i_fix_mask,
  input  logic          i_gnt,
  input  logic [DW-1:0] i_ram_dout,
  input  logic          i_mif_wr_hit,
  output logic          o_req,
  output logic          o_wr,
  output logic [DW-1:0] o_wdat,
  output logic          o_done
);

  fix_state_e    r_state, w_state_nxt;
  logic [DW-1:0] r_word, w_word_nxt;
  logic          r_done, w_done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FixIdle;
      r_word  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_done_nxt  = 1'b0;
    o_req       = 1'b0;
    o_wr        = 1'b0;
    unique case (r_state)
      FixIdle: begin
        if (i_fix_req) w_state_nxt = FixIdle == FixIdle ? FixRd : FixIdle;
      end
      FixRd: begin
        if (!i_fix_req) begin
          w_state_nxt = FixIdle;
        end else begin
          o_req = 1'b1;
          if (i_gnt) w_state_nxt = FixCap;
        end
      end
      FixCap: begin
        w_word_nxt  = i_ram_dout ^ i_fix_mask;
        // A concurrent write to the same word makes the captured data stale.
        w_state_nxt = i_mif_wr_hit ? FixRd : FixWr;
      end
      FixWr: begin
        if (!i_fix_req) begin
          w_state_nxt = FixIdle;
        end else if (i_mif_wr_hit) begin
          w_state_nxt = FixRd;
        end else begin
          o_req = 1'b1;
          o_wr  = 1'b1;
          if (i_gnt) begin
            w_state_nxt = FixIdle;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = FixIdle;
    endcase
  end

  assign o_wdat = r_word;
  assign o_done = r_done;

endmodule

// File: rtl/nfc_ram_arb.sv
// Single-port SRAM arbiter: memory interface first, then round-robin between the ECC fixer
// and the host.
module nfc_ram_arb
  import nfc_parameter::*;
#(
  parameter int unsigned AW = nfc_parameter::AW,
  parameter int unsigned DW = nfc_parameter::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] mif_ram_addr,
  input  logic          mif_ram_cen,
  input  logic [1:0]    mif_ram_wen,
  input  logic [DW-1:0] mif_ram_din,
  output logic [DW-1:0] mif_ram_dout,
  input  logic          fix_req,
  input  logic [AW-1:0] fix_addr,
  input  logic [DW-1:0] fix_mask,
  output logic          fix_done,
  input  logic          hst_req,
  input  logic          hst_wr,
  input  logic [AW-1:0] hst_addr,
  input  logic [1:0]    hst_be,
  input  logic [DW-1:0] hst_wdat,
  output logic          hst_gnt,
  output logic          hst_rvld,
  output logic [DW-1:0] hst_rdat,
  output logic [AW-1:0] ram_addr,
  output logic          ram_cen,
  output logic [1:0]    ram_wen,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  owner_e        w_owner;
  logic          r_run;
  logic          r_rr_fix;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_din;
  logic          r_hst_rvld;
  logic          w_fix_req;
  logic          w_fix_wr;
  logic [DW-1:0] w_fix_wdat;
  logic          w_mif_wr_hit;

  assign w_mif_wr_hit = r_run && !mif_ram_cen && (mif_ram_wen != 2'b11) &&
                        (mif_ram_addr == fix_addr);

  nfc_ecc_fix #(
    .DW (DW)
  ) u_fix (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_fix_req    (fix_req),
    .i_fix_mask   (fix_mask),
    .i_gnt        (w_owner == OwnFix),
    .i_ram_dout   (ram_dout),
    .i_mif_wr_hit (w_mif_wr_hit),
    .o_req        (w_fix_req),
    .o_wr         (w_fix_wr),
    .o_wdat       (w_fix_wdat),
    .o_done       (fix_done)
  );

  // r_run keeps the port quiet until the first clock edge after reset is released.
  always_comb begin
    w_owner = OwnNone;
    if (r_run) begin
      if (!mif_ram_cen) begin
        w_owner = OwnMif;
      end else if (w_fix_req && hst_req) begin
        w_owner = r_rr_fix ? OwnFix : OwnHst;
      end else if (w_fix_req) begin
        w_owner = OwnFix;
      end else if (hst_req) begin
        w_owner = OwnHst;
      end
    end
  end

  always_comb begin
    ram_cen  = 1'b1;
    ram_wen  = 2'b11;
    ram_addr = r_addr;
    ram_din  = r_din;
    unique case (w_owner)
      OwnMif: begin
        ram_cen  = 1'b0;
        ram_wen  = mif_ram_wen;
        ram_addr = mif_ram_addr;
        ram_din  = mif_ram_din;
      end
      OwnFix: begin
        ram_cen  = 1'b0;
        ram_wen  = w_fix_wr ? 2'b00 : 2'b11;
        ram_addr = fix_addr;
        ram_din  = w_fix_wdat;
      end
      OwnHst: begin
        ram_cen  = 1'b0;
        ram_wen  = host_wen(hst_wr, hst_be);
        ram_addr = hst_addr;
        ram_din  = hst_wdat;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_rr_fix   <= 1'b1;
      r_addr     <= '0;
      r_din      <= '0;
      r_hst_rvld <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_hst_rvld <= (w_owner == OwnHst) && !hst_wr;
      if (w_owner == OwnFix || w_owner == OwnHst) r_rr_fix <= ~r_rr_fix;
      if (w_owner != OwnNone) begin
        r_addr <= ram_addr;
        r_din  <= ram_din;
      end
    end
  end

  assign hst_gnt      = (w_owner == OwnHst);
  assign hst_rvld     = r_hst_rvld;
  assign hst_rdat     = ram_dout;
  assign mif_ram_dout = ram_dout;

endmodule

// File: tb/tb_nfc_ram_arb.sv
// Self-checking bench for nfc_ram_arb with a behavioural single-port SRAM.
module tb_nfc_ram_arb;

  typedef struct packed {
    logic [12:0] addr;
    logic [1:0]  wen;
    logic [15:0] din;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] mif_ram_addr;
  logic        mif_ram_cen;
  logic [1:0]  mif_ram_wen;
  logic [15:0] mif_ram_din;
  logic [15:0] mif_ram_dout;
  logic        fix_req;
  logic [12:0] fix_addr;
  logic [15:0] fix_mask;
  logic        fix_done;
  logic        hst_req;
  logic        hst_wr;
  logic [12:0] hst_addr;
  logic [1:0]  hst_be;
  logic [15:0] hst_wdat;
  logic        hst_gnt;
  logic        hst_rvld;
  logic [15:0] hst_rdat;
  logic [12:0] ram_addr;
  logic        ram_cen;
  logic [1:0]  ram_wen;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;

  logic [15:0] mem [0:8191];
  acc_t        exp_q[$];
  acc_t        obs_q[$];
  logic [7:0]  rd_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  nfc_ram_arb #(
    .AW (13),
    .DW (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mif_ram_addr (mif_ram_addr),
    .mif_ram_cen  (mif_ram_cen),
    .mif_ram_wen  (mif_ram_wen),
    .mif_ram_din  (mif_ram_din),
    .mif_ram_dout (mif_ram_dout),
    .fix_req      (fix_req),
    .fix_addr     (fix_addr),
    .fix_mask     (fix_mask),
    .fix_done     (fix_done),
    .hst_req      (hst_req),
    .hst_wr       (hst_wr),
    .hst_addr     (hst_addr),
    .hst_be       (hst_be),
    .hst_wdat     (hst_wdat),
    .hst_gnt      (hst_gnt),
    .hst_rvld     (hst_rvld),
    .hst_rdat     (hst_rdat),
    .ram_addr     (ram_addr),
    .ram_cen      (ram_cen),
    .ram_wen      (ram_wen),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout)
  );

  always @(posedge clk) begin
    if (ram_cen === 1'b0) begin
      if (ram_wen[0] === 1'b0) mem[ram_addr][7:0] <= ram_din[7:0];
      if (ram_wen[1] === 1'b0) mem[ram_addr][15:8] <= ram_din[15:8];
      ram_dout <= mem[ram_addr];
    end
  end

  always @(negedge clk) begin
    acc_t a;
    if (rst_n === 1'b1 && ram_cen === 1'b0) begin
      a.addr = ram_addr;
      a.wen  = ram_wen;
      a.din  = (ram_wen == 2'b11) ? 16'h0000 : ram_din;
      obs_q.push_back(a);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mif_ram_addr = '0;
    mif_ram_cen  = 1'b1;
    mif_ram_wen  = 2'b11;
    mif_ram_din  = '0;
    fix_req      = 1'b0;
    fix_addr     = '0;
    fix_mask     = '0;
    hst_req      = 1'b0;
    hst_wr       = 1'b0;
    hst_addr     = '0;
    hst_be       = 2'b00;
    hst_wdat     = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    hst_req     = 1'b1;
    hst_addr    = 13'h0300;
    fix_req     = 1'b1;
    fix_addr    = 13'h0100;
    mif_ram_cen = 1'b0;
    mif_ram_wen = 2'b00;
    rst_n       = 1'b0;
    tick();
    tick();
    @(negedge clk);
    n_cmp++; if (ram_cen !== 1'b1) begin n_bad++; $display("FAIL rst_cen: got %b want 1", ram_cen); end
    n_cmp++; if (ram_wen !== 2'b11) begin n_bad++; $display("FAIL rst_wen: got %b want 11", ram_wen); end
    n_cmp++; if (hst_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_gnt: got %b want 0", hst_gnt); end
    n_cmp++; if (fix_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", fix_done); end
    n_cmp++; if (hst_rvld !== 1'b0) begin n_bad++; $display("FAIL rst_rvld: got %b want 0", hst_rvld); end
    fix_req     = 1'b0;
    mif_ram_cen = 1'b1;
    mif_ram_wen = 2'b11;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (hst_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_hold_gnt: got %b want 0", hst_gnt); end
    tick();
    @(negedge clk);
    n_cmp++; if (hst_gnt !== 1'b1) begin n_bad++; $display("FAIL rst_first_gnt: got %b want 1", hst_gnt); end
    tick();
    hst_req = 1'b0;
  endtask

  task automatic test_mif_priority();
    logic [12:0] ta [4] = '{13'h0200, 13'h0201, 13'h0200, 13'h0202};
    logic [1:0]  tw [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [15:0] td [4] = '{16'hBEEF, 16'h00C3, 16'h0000, 16'h7700};
    hst_req  = 1'b1;
    hst_wr   = 1'b1;
    hst_addr = 13'h0055;
    hst_be   = 2'b11;
    hst_wdat = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      mif_ram_cen  = 1'b0;
      mif_ram_addr = ta[i];
      mif_ram_wen  = tw[i];
      mif_ram_din  = td[i];
      @(negedge clk);
      n_cmp++;
      if (hst_gnt !== 1'b0) begin n_bad++; $display("FAIL mif_block_gnt[%0d]: got %b want 0", i, hst_gnt); end
      n_cmp++;
      if ({ram_cen, ram_addr, ram_wen, ram_din} !== {1'b0, ta[i], tw[i], td[i]}) begin
        n_bad++;
        $display("FAIL mif_pass[%0d]: got %b/%h/%b/%h want 0/%h/%b/%h", i, ram_cen, ram_addr,
                 ram_wen, ram_din, ta[i], tw[i], td[i]);
      end
      if (i == 3) begin
        n_cmp++;
        if (mif_ram_dout !== 16'hBEEF) begin
          n_bad++; $display("FAIL mif_dout: got %h want beef", mif_ram_dout);
        end
      end
      tick();
    end
    mif_ram_cen = 1'b1;
    mif_ram_wen = 2'b11;
    @(negedge clk);
    n_cmp++; if (hst_gnt !== 1'b1) begin n_bad++; $display("FAIL mif_release_gnt: got %b want 1", hst_gnt); end
    n_cmp++; if (ram_wen !== 2'b00) begin n_bad++; $display("FAIL mif_release_wen: got %b want 00", ram_wen); end
    tick();
    hst_req = 1'b0;
  endtask

  task automatic test_host_rw();
    logic       got;
    logic [7:0] want;
    hst_req  = 1'b1;
    hst_wr   = 1'b1;
    hst_addr = 13'h0010;
    hst_be   = 2'b01;
    hst_wdat = 16'hA55A;
    for (int pass = 0; pass < 2; pass++) begin
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        @(negedge clk);
        if (hst_gnt === 1'b1) got = 1'b1;
        else tick();
      end
      n_cmp++;
      if (!got) begin n_bad++; $display("FAIL host_gnt_timeout[%0d]: got none want grant", pass); end
      if (pass == 0) begin
        n_cmp++;
        if ({ram_addr, ram_wen, ram_din} !== {13'h0010, 2'b10, 16'hA55A}) begin
          n_bad++;
          $display("FAIL host_wr: got %h/%b/%h want 0010/10/a55a", ram_addr, ram_wen, ram_din);
        end
        tick();
        hst_wr = 1'b0;
      end else begin
        rd_q.push_back(8'h5A);
        n_cmp++; if (ram_wen !== 2'b11) begin n_bad++; $display("FAIL host_rd_wen: got %b want 11", ram_wen); end
        n_cmp++; if (hst_rvld !== 1'b0) begin n_bad++; $display("FAIL host_rvld_early: got %b want 0", hst_rvld); end
        tick();
        hst_req = 1'b0;
      end
    end
    @(negedge clk);
    n_cmp++;
    if (hst_rvld !== 1'b1) begin n_bad++; $display("FAIL host_rvld: got %b want 1", hst_rvld); end
    if (hst_rvld === 1'b1 && rd_q.size() > 0) begin
      want = rd_q.pop_front();
      n_cmp++;
      if (hst_rdat[7:0] !== want) begin
        n_bad++; $display("FAIL host_rdat_lo: got %h want %h", hst_rdat[7:0], want);
      end
    end
    tick();
    @(negedge clk);
    n_cmp++; if (hst_rvld !== 1'b0) begin n_bad++; $display("FAIL host_rvld_pulse: got %b want 0", hst_rvld); end
    rd_q.delete();
    tick();
  endtask

  task automatic run_fix(input int ncyc, input int mif_cyc, input logic [15:0] mif_data,
                         output int done_cyc);
    done_cyc = -1;
    for (int c = 0; c < ncyc; c++) begin
      if (c == mif_cyc) begin
        mif_ram_cen  = 1'b0;
        mif_ram_addr = fix_addr;
        mif_ram_wen  = 2'b00;
        mif_ram_din  = mif_data;
      end else begin
        mif_ram_cen = 1'b1;
        mif_ram_wen = 2'b11;
      end
      @(negedge clk);
      if (fix_done === 1'b1) begin
        if (done_cyc < 0) done_cyc = c;
        fix_req = 1'b0;
      end
      tick();
    end
  endtask

  task automatic test_fix_basic();
    int   done_cyc;
    acc_t e, o;
    mif_ram_cen  = 1'b0;
    mif_ram_addr = 13'h0100;
    mif_ram_wen  = 2'b00;
    mif_ram_din  = 16'h1234;
    tick();
    mif_ram_cen = 1'b1;
    mif_ram_wen = 2'b11;
    obs_q.delete();
    fix_req  = 1'b1;
    fix_addr = 13'h0100;
    fix_mask = 16'h0081;
    exp_q.push_back('{addr: 13'h0100, wen: 2'b11, din: 16'h0000});
    exp_q.push_back('{addr: 13'h0100, wen: 2'b00, din: 16'h12B5});
    run_fix(8, -1, 16'h0000, done_cyc);
    n_cmp++; if (done_cyc != 4) begin n_bad++; $display("FAIL fix_done_cycle: got %0d want 4", done_cyc); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL fix_acc_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL fix_acc: got %h want %h", o, e); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_fix_collision();
    int   done_cyc;
    acc_t e, o;
    obs_q.delete();
    fix_req  = 1'b1;
    fix_addr = 13'h0100;
    fix_mask = 16'h0081;
    exp_q.push_back('{addr: 13'h0100, wen: 2'b11, din: 16'h0000});
    exp_q.push_back('{addr: 13'h0100, wen: 2'b00, din: 16'h5A00});
    exp_q.push_back('{addr: 13'h0100, wen: 2'b11, din: 16'h0000});
    exp_q.push_back('{addr: 13'h0100, wen: 2'b00, din: 16'h5A81});
    run_fix(10, 2, 16'h5A00, done_cyc);
    n_cmp++; if (done_cyc != 6) begin n_bad++; $display("FAIL coll_done_cycle: got %0d want 6", done_cyc); end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL coll_acc_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL coll_acc: got %h want %h", o, e); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_contention();
    logic        eg [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [12:0] ea [4] = '{13'h0100, 13'h0300, 13'h0100, 13'h0300};
    logic [1:0]  ew [4] = '{2'b11, 2'b11, 2'b00, 2'b11};
    idle_inputs();
    fix_req  = 1'b1;
    fix_addr = 13'h0100;
    fix_mask = 16'h0000;
    hst_req  = 1'b1;
    hst_wr   = 1'b0;
    hst_addr = 13'h0300;
    rst_n    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (hst_gnt !== 1'b0) begin n_bad++; $display("FAIL cont_pre_gnt: got %b want 0", hst_gnt); end
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk);
      n_cmp++;
      if ({hst_gnt, ram_addr, ram_wen} !== {eg[c], ea[c], ew[c]}) begin
        n_bad++;
        $display("FAIL cont_owner[%0d]: got gnt=%b addr=%h wen=%b want gnt=%b addr=%h wen=%b",
                 c, hst_gnt, ram_addr, ram_wen, eg[c], ea[c], ew[c]);
      end
      if (c == 3) begin
        n_cmp++;
        if (fix_done !== 1'b1) begin n_bad++; $display("FAIL cont_done: got %b want 1", fix_done); end
      end
      if (fix_done === 1'b1) fix_req = 1'b0;
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    idle_inputs();
    obs_q.delete();
    fix_req  = 1'b1;
    fix_addr = 13'h0120;
    fix_mask = 16'h0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tick();
    end
    rst_n   = 1'b0;
    fix_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ram_cen, ram_wen, hst_gnt, hst_rvld, fix_done} !== {1'b1, 2'b11, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL mid_rst_outputs: got cen=%b wen=%b gnt=%b rvld=%b done=%b want 1/11/0/0/0",
               ram_cen, ram_wen, hst_gnt, hst_rvld, fix_done);
    end
    tick();
    rst_n    = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (fix_done === 1'b1) saw_done = 1'b1;
      tick();
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_done: got 1 want 0"); end
    n_cmp++;
    if (obs_q.size() != 1) begin
      n_bad++; $display("FAIL mid_rst_acc_count: got %0d want 1", obs_q.size());
    end else begin
      n_cmp++;
      if (obs_q[0] !== acc_t'{addr: 13'h0120, wen: 2'b11, din: 16'h0000}) begin
        n_bad++; $display("FAIL mid_rst_acc: got %h want read of 0120", obs_q[0]);
      end
    end
    obs_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_mif_priority();
    test_host_rw();
    test_fix_basic();
    test_fix_collision();
    test_contention();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
